atm_timeout_scheduler: RTL and testbench
========================================

# atm_timeout_scheduler

Shared timeout scheduler for the ATM controller. A single prescaler divides the 100 MHz system clock into a slow tick, and that tick is shared by NUM_CH independent countdown channels (e.g. PIN-entry timeout, session idle timeout, card-eject timeout). Each channel is started, cancelled and reported through a simple pulse interface. The prescaler runs only while at least one channel is counting.

## Interface
Parameters:
- PRESCALE, 256: clk cycles per tick; legal range 2..2^16.
- NUM_CH, 3: number of timeout channels; legal range 1..8.
- CNT_W, 8: width of each channel's duration/remaining count.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  NUM_CH  one-cycle pulse per channel; loads the duration and begins counting.
- cancel  input  NUM_CH  one-cycle pulse per channel; aborts counting with no expiry.
- dur  input  NUM_CH*CNT_W  per-channel duration in ticks; channel i uses dur[i*CNT_W +: CNT_W], sampled only on start[i].
- busy  output  NUM_CH  channel counting (RUN state).
- expired  output  NUM_CH  one-cycle pulse when the channel times out.
- remaining  output  NUM_CH*CNT_W  per-channel ticks left; 0 when idle.
- tick  output  1  one-cycle pulse each time the prescaler wraps.

## Operation
- Prescaler, pcnt:
  - log2(PRESCALE)-bit counter; held at 0 while no channel is in RUN.
  - While any channel is in RUN, increments every cycle. At pcnt == PRESCALE-1 it wraps to 0 and tick is asserted in that same cycle (tick is registered).
  - When the last running channel leaves RUN, pcnt returns to 0 on the next cycle.
- Per-channel FSM with states IDLE, RUN and EXP:
  - IDLE: start with dur > 0 goes to RUN and loads remaining = dur. start with dur == 0 goes to EXP.
  - RUN, on tick: remaining decrements. If remaining == 1 at the tick, go to EXP and set remaining to 0.
  - RUN, on cancel: go to IDLE and set remaining to 0.
  - RUN, on start: restart, reloading dur. The prescaler phase is not reset.
  - EXP: lasts exactly one cycle with expired[i] = 1, then goes to IDLE. A start in the EXP cycle is taken and the next state is RUN (or EXP again if dur == 0).
- Simultaneous events:
  - start and cancel in the same cycle: cancel wins, next state is IDLE.
  - cancel on the same cycle as the final tick: cancel wins, and expired is not pulsed.
  - start on the same cycle as a tick in RUN: the reload wins, and that tick is not applied.
- busy[i] is 1 exactly in RUN. Outputs are registered directly from state; there is no combinational path from inputs to outputs.
- Channels are fully independent. Any combination of simultaneous expiries is reported in the same cycle.
- Reset, including mid-count: all channels go to IDLE, pcnt = 0, and no expired pulse is generated.

## Timing
- Reset values: busy = 0, expired = 0, remaining = 0, tick = 0.
- Start to busy: busy rises 1 cycle after start.
- Expiry latency when the prescaler is idle: start in cycle t with dur = N > 0 gives a tick in cycles t+k*PRESCALE (k ≥ 1) and expired high in cycle t+N*PRESCALE+1.
- Expiry latency when the prescaler is already running: the first tick is a partial period. Latency lies between (N-1)*PRESCALE+2 and N*PRESCALE+1 cycles; the jitter is accepted by design.
- dur == 0: expired pulses in cycle t+1.
- expired width: exactly 1 cycle per timeout.
- Countdown width: remaining never wraps below 0.
- Maximum timeout: (2^CNT_W - 1) * PRESCALE cycles.

## Test plan
- Basic timeout (PRESCALE=4, CNT_W=8):
  - Stimulus: start[0] with dur=3 at cycle 10.
  - Response: busy[0] from cycle 11; tick at cycles 14, 18 and 22; remaining steps 3, 2, 1; expired[0] in cycle 23 only; busy[0] = 0 from cycle 23.
- Cancel:
  - Stimulus: start[1] with dur=5, then cancel[1] after 2 ticks.
  - Response: busy[1] falls the next cycle, remaining = 0, no expired pulse, tick stops, pcnt = 0.
- Contention:
  - Stimulus: start[2] and cancel[2] together; then, in a separate case, cancel coincident with the final tick.
  - Response: the channel stays IDLE; no expired pulse.
- Sharing:
  - Stimulus: start[0] with dur=2 at cycle 10; start[1] with dur=2 at cycle 12.
  - Response: both share ticks at 14 and 18; both channels pulse expired in cycle 19.
- Restart and zero duration:
  - Stimulus: re-start ch0 with dur=4 while it has remaining = 1; start with dur=0.
  - Response: after the re-start, remaining = 4 and no expiry occurs. With dur=0, expired pulses 1 cycle after start and busy stays 0.
- Reset mid-count:
  - Stimulus: assert reset asynchronously between clock edges while all channels are running.
  - Response: all outputs go to 0 immediately; after reset deasserts, no spurious tick or expired appears.

Source files
------------

// File: rtl/atm_timeout_scheduler.sv
// Shared-prescaler timeout scheduler: one slow tick drives NUM_CH independent
// countdown channels, each started, cancelled and reported through single-cycle pulses.
module atm_timeout_scheduler #(
  parameter int PRESCALE = 256,
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         cancel,
  input  logic [NUM_CH*CNT_W-1:0]   dur,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         expired,
  output logic [NUM_CH*CNT_W-1:0]   remaining,
  output logic                      tick
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXP} state_t;

  state_t           state_q [NUM_CH];
  state_t           state_n [NUM_CH];
  logic [CNT_W-1:0] rem_q   [NUM_CH];
  logic [CNT_W-1:0] rem_n   [NUM_CH];
  logic [CNT_W-1:0] dur_ch  [NUM_CH];
  logic [PW-1:0]    pcnt;
  logic [PW-1:0]    pcnt_n;
  logic             run_any;
  logic             run_any_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign dur_ch[g]                   = dur[g*CNT_W +: CNT_W];
    assign busy[g]                     = (state_q[g] == RUN);
    assign expired[g]                  = (state_q[g] == EXP);
    assign remaining[g*CNT_W +: CNT_W] = rem_q[g];
  end

  // Priority inside RUN is cancel, then reload, then tick, so a coincident
  // cancel suppresses the final expiry and a reload swallows the tick.
  always_comb begin
    run_any   = 1'b0;
    run_any_n = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_n[i] = state_q[i];
      rem_n[i]   = rem_q[i];
      if (cancel[i]) begin
        state_n[i] = IDLE;
        rem_n[i]   = '0;
      end else if (start[i]) begin
        state_n[i] = (dur_ch[i] == '0) ? EXP : RUN;
        rem_n[i]   = dur_ch[i];
      end else if (state_q[i] == RUN) begin
        if (tick) begin
          if (rem_q[i] <= CNT_W'(1)) begin
            state_n[i] = EXP;
            rem_n[i]   = '0;
          end else begin
            rem_n[i] = rem_q[i] - CNT_W'(1);
          end
        end
      end else begin
        state_n[i] = IDLE;
        rem_n[i]   = '0;
      end
      run_any   = run_any   | (state_q[i] == RUN);
      run_any_n = run_any_n | (state_n[i] == RUN);
    end
    pcnt_n = '0;
    if (run_any) begin
      pcnt_n = (pcnt == PMAX) ? '0 : pcnt + PW'(1);
    end
  end

  // Tick is registered against the next prescaler value so it is high in the
  // very cycle pcnt sits at its wrap point, and never while nothing is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        rem_q[i]   <= '0;
      end
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_n[i];
        rem_q[i]   <= rem_n[i];
      end
      pcnt <= pcnt_n;
      tick <= run_any_n && (pcnt_n == PMAX);
    end
  end

endmodule

// File: tb/tb_atm_timeout_scheduler.sv
// Directed bench for atm_timeout_scheduler with PRESCALE=4, three 8-bit channels;
// expected values are hand-derived cycle by cycle relative to each start pulse.
module tb_atm_timeout_scheduler;

  localparam int P = 4;
  localparam int N = 3;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   start;
  logic [N-1:0]   cancel;
  logic [N*W-1:0] dur;
  logic [N-1:0]   busy;
  logic [N-1:0]   expired;
  logic [N*W-1:0] remaining;
  logic           tick;

  int tests_run    = 0;
  int tests_failed = 0;

  atm_timeout_scheduler #(.PRESCALE(P), .NUM_CH(N), .CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cancel    (cancel),
    .dur       (dur),
    .busy      (busy),
    .expired   (expired),
    .remaining (remaining),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] remOf(input int ch);
    return remaining[ch*W +: W];
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = '0;
    cancel = '0;
    dur    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_expired", 32'(expired), 0);
    checkOutput("rst_remaining", 32'(remaining), 0);
    checkOutput("rst_tick", 32'(tick), 0);
    reset = 1'b0;
    repeat (2) stepCycle();

    // Basic timeout: ch0, dur=3
    dur[7:0] = 8'd3;
    start    = 3'b001;
    stepCycle();
    start = '0;
    for (int k = 1; k <= 12; k++) begin
      checkOutput($sformatf("basic_tick@%0d", k), 32'(tick), (k % 4 == 0) ? 1 : 0);
      checkOutput($sformatf("basic_rem@%0d", k), 32'(remOf(0)), (k <= 4) ? 3 : (k <= 8) ? 2 : 1);
      checkOutput($sformatf("basic_busy@%0d", k), 32'(busy), 32'b001);
      checkOutput($sformatf("basic_exp@%0d", k), 32'(expired), 0);
      stepCycle();
    end
    checkOutput("basic_exp_pulse", 32'(expired), 32'b001);
    checkOutput("basic_busy_off", 32'(busy), 0);
    checkOutput("basic_rem_zero", 32'(remOf(0)), 0);
    checkOutput("basic_tick_off", 32'(tick), 0);
    stepCycle();
    checkOutput("basic_exp_width", 32'(expired), 0);

    // Cancel after two ticks: ch1, dur=5
    repeat (2) stepCycle();
    dur[15:8] = 8'd5;
    start     = 3'b010;
    stepCycle();
    start = '0;
    repeat (8) stepCycle();
    checkOutput("cancel_rem_before", 32'(remOf(1)), 3);
    cancel = 3'b010;
    stepCycle();
    cancel = '0;
    checkOutput("cancel_busy", 32'(busy), 0);
    checkOutput("cancel_rem", 32'(remOf(1)), 0);
    checkOutput("cancel_exp", 32'(expired), 0);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("cancel_quiet_tick@%0d", k), 32'(tick), 0);
      checkOutput($sformatf("cancel_quiet_exp@%0d", k), 32'(expired), 0);
      stepCycle();
    end

    // Start and cancel together on ch2
    dur[23:16] = 8'd5;
    start      = 3'b100;
    cancel     = 3'b100;
    stepCycle();
    start  = '0;
    cancel = '0;
    checkOutput("sc_busy", 32'(busy), 0);
    checkOutput("sc_rem", 32'(remOf(2)), 0);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("sc_tick@%0d", k), 32'(tick), 0);
      checkOutput($sformatf("sc_exp@%0d", k), 32'(expired), 0);
      stepCycle();
    end

    // Cancel coincident with the final tick on ch2
    dur[23:16] = 8'd1;
    start      = 3'b100;
    stepCycle();
    start = '0;
    checkOutput("ft_busy", 32'(busy), 32'b100);
    checkOutput("ft_rem", 32'(remOf(2)), 1);
    repeat (3) stepCycle();
    checkOutput("ft_tick", 32'(tick), 1);
    cancel = 3'b100;
    stepCycle();
    cancel = '0;
    checkOutput("ft_exp", 32'(expired), 0);
    checkOutput("ft_busy_off", 32'(busy), 0);
    checkOutput("ft_rem_zero", 32'(remOf(2)), 0);
    stepCycle();
    checkOutput("ft_exp_late", 32'(expired), 0);
    checkOutput("ft_tick_off", 32'(tick), 0);

    // Sharing: ch0 at rel 0, ch1 at rel 2, both dur=2
    repeat (2) stepCycle();
    dur[7:0] = 8'd2;
    start    = 3'b001;
    stepCycle();
    start = '0;
    stepCycle();
    dur[15:8] = 8'd2;
    start     = 3'b010;
    stepCycle();
    start = '0;
    checkOutput("share_busy", 32'(busy), 32'b011);
    checkOutput("share_rem1_load", 32'(remOf(1)), 2);
    stepCycle();
    checkOutput("share_tick4", 32'(tick), 1);
    checkOutput("share_rem0_c4", 32'(remOf(0)), 2);
    repeat (4) stepCycle();
    checkOutput("share_tick8", 32'(tick), 1);
    checkOutput("share_rem0_c8", 32'(remOf(0)), 1);
    checkOutput("share_rem1_c8", 32'(remOf(1)), 1);
    stepCycle();
    checkOutput("share_exp_both", 32'(expired), 32'b011);
    checkOutput("share_busy_off", 32'(busy), 0);
    stepCycle();
    checkOutput("share_exp_width", 32'(expired), 0);

    // Restart while remaining=1, then reload on a tick cycle
    repeat (2) stepCycle();
    dur[7:0] = 8'd2;
    start    = 3'b001;
    stepCycle();
    start = '0;
    repeat (4) stepCycle();
    checkOutput("rs_rem_c5", 32'(remOf(0)), 1);
    stepCycle();
    dur[7:0] = 8'd4;
    start    = 3'b001;
    stepCycle();
    start = '0;
    checkOutput("rs_rem_c7", 32'(remOf(0)), 4);
    checkOutput("rs_busy_c7", 32'(busy), 32'b001);
    stepCycle();
    checkOutput("rs_tick_c8", 32'(tick), 1);
    stepCycle();
    checkOutput("rs_rem_c9", 32'(remOf(0)), 3);
    checkOutput("rs_exp_c9", 32'(expired), 0);
    repeat (3) stepCycle();
    checkOutput("rs_tick_c12", 32'(tick), 1);
    dur[7:0] = 8'd7;
    start    = 3'b001;
    stepCycle();
    start = '0;
    checkOutput("rs_reload_on_tick", 32'(remOf(0)), 7);
    checkOutput("rs_exp_c13", 32'(expired), 0);
    repeat (3) stepCycle();
    checkOutput("rs_tick_c16", 32'(tick), 1);
    stepCycle();
    checkOutput("rs_rem_c17", 32'(remOf(0)), 6);
    cancel = 3'b001;
    stepCycle();
    cancel = '0;
    checkOutput("rs_busy_off", 32'(busy), 0);

    // Zero duration on ch1
    repeat (2) stepCycle();
    dur[15:8] = 8'd0;
    start     = 3'b010;
    stepCycle();
    start = '0;
    checkOutput("zero_exp", 32'(expired), 32'b010);
    checkOutput("zero_busy", 32'(busy), 0);
    checkOutput("zero_rem", 32'(remOf(1)), 0);
    stepCycle();
    checkOutput("zero_exp_width", 32'(expired), 0);
    checkOutput("zero_busy_after", 32'(busy), 0);
    checkOutput("zero_tick", 32'(tick), 0);

    // Asynchronous reset mid-count with all channels running
    dur   = {8'd10, 8'd10, 8'd10};
    start = 3'b111;
    stepCycle();
    start = '0;
    repeat (5) stepCycle();
    checkOutput("mr_busy_pre", 32'(busy), 32'b111);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mr_busy", 32'(busy), 0);
    checkOutput("mr_expired", 32'(expired), 0);
    checkOutput("mr_remaining", 32'(remaining), 0);
    checkOutput("mr_tick", 32'(tick), 0);
    #2;
    reset = 1'b0;
    stepCycle();
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("mr_post_tick@%0d", k), 32'(tick), 0);
      checkOutput($sformatf("mr_post_exp@%0d", k), 32'(expired), 0);
      checkOutput($sformatf("mr_post_busy@%0d", k), 32'(busy), 0);
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
